// File: rtl/two_port_ram_be.sv
// two_port_ram_be: one-write / one-read synchronous RAM with per-lane byte
// enables, 1- or 2-cycle read latency, optional read-during-write bypass and
// a power-up clear sequencer that writes CLEAR_VALUE to every word.
//
// Ports:
//   clk            - single clock, rising edge
//   rst            - synchronous, active-high reset (memory contents untouched)
//   write_enable   - write request, honoured only once init_done=1
//   write_address  - write location
//   write_data     - write word
//   write_byte_en  - lane i covers write_data[i*LANE_WIDTH +: LANE_WIDTH]
//   read_enable    - read request, honoured only once init_done=1
//   read_address   - read location
//   read_data      - read result, held between deliveries
//   read_valid     - one-cycle pulse per accepted read
//   init_done      - clear sequence finished, user ports live
module two_port_ram_be #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned LANE_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned BYPASS       = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               write_enable,
    input  logic [ADDR_WIDTH-1:0]              write_address,
    input  logic [DATA_WIDTH-1:0]              write_data,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   write_byte_en,
    input  logic                               read_enable,
    input  logic [ADDR_WIDTH-1:0]              read_address,
    output logic [DATA_WIDTH-1:0]              read_data,
    output logic                               read_valid,
    output logic                               init_done
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned NLANES = DATA_WIDTH / LANE_WIDTH;

    // Elaboration-time parameter sanity.
    if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lane
        $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
    end
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_lat
        $error("READ_LATENCY must be 1 or 2");
    end

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Init sequencer state
    // ------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  init_done_q, init_done_d;

    // Read pipeline
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

    // Qualified requests and read-side datapath
    logic                  clearing_c;
    logic                  wr_fire_c;
    logic                  rd_fire_c;
    logic                  collide_c;
    logic [DATA_WIDTH-1:0] wr_mask_c;
    logic [DATA_WIDTH-1:0] rd_old_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    // User ports are only live once the clear sequence has completed.
    assign clearing_c = (state_q == ST_CLEAR);
    assign wr_fire_c  = (state_q == ST_READY) && write_enable;
    assign rd_fire_c  = (state_q == ST_READY) && read_enable;
    assign collide_c  = wr_fire_c && rd_fire_c && (read_address == write_address);

    // Expand lane enables into a bit mask for the bypass merge.
    always_comb begin
        wr_mask_c = '0;
        for (int unsigned i = 0; i < NLANES; i++) begin
            wr_mask_c[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{write_byte_en[i]}};
        end
    end

    // Read word: old content, optionally overlaid with same-edge write lanes.
    always_comb begin
        rd_old_c  = mem[read_address];
        rd_word_c = rd_old_c;
        if ((BYPASS != 0) && collide_c) begin
            rd_word_c = (rd_old_c & ~wr_mask_c) | (write_data & wr_mask_c);
        end
    end

    // ------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_CLEAR: begin
                // Last address ends the sweep; pointer holds rather than wrapping.
                if (ptr_q == '1) begin
                    state_d     = ST_READY;
                    init_done_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Read stage 1: capture the word sampled at the accepting edge.
    always_comb begin
        s1_valid_d = rd_fire_c;
        s1_data_d  = s1_data_q;
        if (rd_fire_c) begin
            s1_data_d = rd_word_c;
        end
    end

    // Control and read-stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            init_done_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
        end
    end

    // Memory array: no reset, so contents survive rst until the sweep rewrites them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clearing_c) begin
                mem[ptr_q] <= CLEAR_VALUE;
            end else if (wr_fire_c) begin
                for (int unsigned i = 0; i < NLANES; i++) begin
                    if (write_byte_en[i]) begin
                        mem[write_address][i*LANE_WIDTH +: LANE_WIDTH] <=
                            write_data[i*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage selection
    // ------------------------------------------------------------------
    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_valid_q, s2_valid_d;
        logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

        // Second stage only copies stage 1, so a later write cannot disturb it.
        always_comb begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s2_data_q;
            if (s1_valid_q) begin
                s2_data_d = s1_data_q;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_data_q  <= s2_data_d;
            end
        end

        assign read_valid = s2_valid_q;
        assign read_data  = s2_data_q;
    end else begin : g_lat1
        assign read_valid = s1_valid_q;
        assign read_data  = s1_data_q;
    end

    assign init_done = init_done_q;

endmodule

// File: tb/tb_two_port_ram_be.sv
// Bench for two_port_ram_be: two instances share one stimulus stream.
//   dut_a: 32-bit, READ_LATENCY=1, BYPASS=1, CLEAR_VALUE=0
//   dut_b: 32-bit, READ_LATENCY=2, BYPASS=0, CLEAR_VALUE=5A5AA5A5
// Expected reads are queued at issue time with their due cycle; a negedge
// monitor pops and compares data and latency whenever read_valid is seen.
module tb_two_port_ram_be;

    localparam logic [31:0] CV_A = 32'h0000_0000;
    localparam logic [31:0] CV_B = 32'h5A5A_A5A5;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        re;
    logic [7:0]  raddr;

    logic [31:0] a_rdata, b_rdata;
    logic        a_valid, b_valid;
    logic        a_done, b_done;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    two_port_ram_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .LANE_WIDTH(8),
        .READ_LATENCY(1), .BYPASS(1), .CLEAR_VALUE(CV_A)
    ) dut_a (
        .clk(clk), .rst(rst),
        .write_enable(we), .write_address(waddr), .write_data(wdata),
        .write_byte_en(wbe), .read_enable(re), .read_address(raddr),
        .read_data(a_rdata), .read_valid(a_valid), .init_done(a_done)
    );

    two_port_ram_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .LANE_WIDTH(8),
        .READ_LATENCY(2), .BYPASS(0), .CLEAR_VALUE(CV_B)
    ) dut_b (
        .clk(clk), .rst(rst),
        .write_enable(we), .write_address(waddr), .write_data(wdata),
        .write_byte_en(wbe), .read_enable(re), .read_address(raddr),
        .read_data(b_rdata), .read_valid(b_valid), .init_done(b_done)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus; queue expected read results if reading.
    task automatic issue(input logic w, input logic [7:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic r, input logic [7:0] ra,
                         input logic [31:0] ea, input logic [31:0] eb, input bit push_b);
        we    = w;
        waddr = wa;
        wdata = wd;
        wbe   = be;
        re    = r;
        raddr = ra;
        if (r) begin
            q_a.push_back('{ea, cyc + 1});
            if (push_b) q_b.push_back('{eb, cyc + 2});
        end
        tick();
    endtask

    task automatic idle(input int n);
        we = 1'b0; re = 1'b0; wbe = 4'h0;
        waddr = 8'h00; raddr = 8'h00; wdata = 32'h0;
        repeat (n) tick();
    endtask

    // Scoreboard monitor: compare data and arrival cycle; flag strays and misses.
    always @(negedge clk) begin
        if (a_valid) begin
            if (q_a.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL a_unexpected_valid: read_data=%h, none expected (cycle %0d)", a_rdata, cyc);
            end else begin
                mon_e = q_a.pop_front();
                check("a_read_data", a_rdata, mon_e.data);
                check("a_latency_cycle", 32'(cyc), 32'(mon_e.due));
            end
        end else if (q_a.size() != 0 && q_a[0].due <= cyc) begin
            mon_e = q_a.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL a_missing_valid: no read_valid, expected data %h by cycle %0d", mon_e.data, mon_e.due);
        end
        if (b_valid) begin
            if (q_b.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_unexpected_valid: read_data=%h, none expected (cycle %0d)", b_rdata, cyc);
            end else begin
                mon_e = q_b.pop_front();
                check("b_read_data", b_rdata, mon_e.data);
                check("b_latency_cycle", 32'(cyc), 32'(mon_e.due));
            end
        end else if (q_b.size() != 0 && q_b[0].due <= cyc) begin
            mon_e = q_b.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL b_missing_valid: no read_valid, expected data %h by cycle %0d", mon_e.data, mon_e.due);
        end
    end

    initial begin
        rst = 1'b1;
        // Requests held active through the whole clear must be ignored.
        we = 1'b1; waddr = 8'd3; wdata = 32'hDEAD_BEEF; wbe = 4'hF;
        re = 1'b1; raddr = 8'd3;
        repeat (3) tick();
        check("a_reset_read_data", a_rdata, 32'h0);
        check("b_reset_read_data", b_rdata, 32'h0);
        check("a_reset_read_valid", 32'(a_valid), 32'h0);
        check("b_reset_read_valid", 32'(b_valid), 32'h0);
        check("a_reset_init_done", 32'(a_done), 32'h0);
        check("b_reset_init_done", 32'(b_done), 32'h0);

        // Partial clear up to pointer 100, then reset restarts the sweep.
        rst = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            check("a_init_done_partial", 32'(a_done), 32'h0);
            check("b_init_done_partial", 32'(b_done), 32'h0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("a_init_done_after_rst", 32'(a_done), 32'h0);
        for (int k = 1; k <= 256; k++) begin
            tick();
            check("a_init_done_clear", 32'(a_done), (k == 256) ? 32'h1 : 32'h0);
            check("b_init_done_clear", 32'(b_done), (k == 256) ? 32'h1 : 32'h0);
        end
        idle(1);

        // Every word must hold the clear value, including the address hammered during clear.
        for (int i = 0; i < 256; i++) begin
            issue(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'(i), CV_A, CV_B, 1'b1);
        end
        idle(3);

        // Byte-lane merge, then a write with no lanes enabled.
        issue(1'b1, 8'd5, 32'hAABB_CCDD, 4'hF, 1'b0, 8'd0, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 8'd5, 32'h1122_3344, 4'b0101, 1'b0, 8'd0, 32'h0, 32'h0, 1'b1);
        issue(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd5, 32'hAA22_CC44, 32'hAA22_CC44, 1'b1);
        issue(1'b1, 8'd5, 32'hFFFF_FFFF, 4'h0, 1'b0, 8'd0, 32'h0, 32'h0, 1'b1);
        issue(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd5, 32'hAA22_CC44, 32'hAA22_CC44, 1'b1);

        // Same-address collisions: full lanes at 9, lower two lanes at 10.
        issue(1'b1, 8'd9, 32'h0000_00FF, 4'hF, 1'b1, 8'd9, 32'h0000_00FF, CV_B, 1'b1);
        issue(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd9, 32'h0000_00FF, 32'h0000_00FF, 1'b1);
        issue(1'b1, 8'd10, 32'h1234_5678, 4'b0011, 1'b1, 8'd10, 32'h0000_5678, CV_B, 1'b1);
        issue(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd10, 32'h0000_5678, 32'h5A5A_5678, 1'b1);

        // Different addresses in one cycle are independent.
        issue(1'b1, 8'd20, 32'hCAFE_F00D, 4'hF, 1'b1, 8'd5, 32'hAA22_CC44, 32'hAA22_CC44, 1'b1);
        issue(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd20, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);
        idle(3);

        // Back-to-back reads of 1,2,3; write to 1 right after its read is accepted.
        issue(1'b1, 8'd1, 32'h0000_0101, 4'hF, 1'b0, 8'd0, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 8'd2, 32'h0000_0202, 4'hF, 1'b0, 8'd0, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 8'd3, 32'h0000_0303, 4'hF, 1'b0, 8'd0, 32'h0, 32'h0, 1'b1);
        issue(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd1, 32'h0000_0101, 32'h0000_0101, 1'b1);
        issue(1'b1, 8'd1, 32'h0000_EEEE, 4'hF, 1'b1, 8'd2, 32'h0000_0202, 32'h0000_0202, 1'b1);
        issue(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd3, 32'h0000_0303, 32'h0000_0303, 1'b1);
        idle(4);
        check("a_read_data_held", a_rdata, 32'h0000_0303);
        check("b_read_data_held", b_rdata, 32'h0000_0303);
        check("a_read_valid_idle", 32'(a_valid), 32'h0);
        check("b_read_valid_idle", 32'(b_valid), 32'h0);
        issue(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd1, 32'h0000_EEEE, 32'h0000_EEEE, 1'b1);
        idle(3);

        // Reset one edge after a read is accepted: the latency-2 delivery must vanish.
        issue(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd2, 32'h0000_0202, 32'h0, 1'b0);
        re  = 1'b0;
        rst = 1'b1;
        tick();
        check("a_rst_flight_read_data", a_rdata, 32'h0);
        check("b_rst_flight_read_data", b_rdata, 32'h0);
        check("b_rst_flight_read_valid", 32'(b_valid), 32'h0);
        check("a_rst_flight_init_done", 32'(a_done), 32'h0);
        check("b_rst_flight_init_done", 32'(b_done), 32'h0);
        tick();
        check("b_rst_flight_valid_later", 32'(b_valid), 32'h0);
        tick();

        check("a_queue_drained", 32'(q_a.size()), 32'h0);
        check("b_queue_drained", 32'(q_b.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
